seq_mult32: RTL and testbench



---
 rtl/seq_mult32.sv | 135 +++++++++++++
 tb/tb_seq_mult32.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult32.sv
// seq_mult32: multi-cycle radix-2 shift-add multiplier, signed or unsigned.
//
// Operands are converted to magnitudes when they are accepted. One partial
// product is added per cycle for WIDTH cycles. The sign is then applied once,
// and the 64-bit result is written to HI/LO.
//
// Timing, counted from the edge E0 that samples START in IDLE:
//   RUN  E1..E32  - one iteration per edge
//   SIGN E33      - HI/LO written
//   DONE E34      - one-cycle DONE pulse, then back to IDLE
//
// Ports:
//   CLK    - clock; all state updates on the rising edge
//   RESET  - asynchronous reset, active low; abandons any operation in flight
//   START  - request; sampled only in IDLE
//   SIGNED - 1 selects two's-complement operands; sampled with START
//   A, B   - multiplicand and multiplier; sampled with START
//   BUSY   - high in RUN and SIGN
//   DONE   - one-cycle pulse while HI/LO hold a fresh product
//   HI, LO - product[2*WIDTH-1:WIDTH] and product[WIDTH-1:0]; held until
//            the next SIGN edge or reset
module seq_mult32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             SIGNED,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_SIGN,
    ST_DONE
  } state_t;

  state_t state, state_nxt;

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               neg;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] acc_add;
  logic [2*WIDTH-1:0] acc_fin;
  logic               last_iter;

  // Magnitude of the most negative value wraps to itself.
  // Read as unsigned, that wrapped value is the correct magnitude.
  always_comb begin
    a_mag     = (SIGNED && A[WIDTH-1]) ? ('0 - A) : A;
    b_mag     = (SIGNED && B[WIDTH-1]) ? ('0 - B) : B;
    acc_add   = acc + ({{WIDTH{1'b0}}, mcand} << cnt);
    acc_fin   = neg ? ('0 - acc) : acc;
    last_iter = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    BUSY      = 1'b0;
    DONE      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (START) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        BUSY = 1'b1;
        if (last_iter) state_nxt = ST_SIGN;
      end
      ST_SIGN: begin
        BUSY      = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        DONE      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      HI     <= '0;
      LO     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (START) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            neg    <= SIGNED & (A[WIDTH-1] ^ B[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
          end
        end
        ST_RUN: begin
          if (mplier[0]) acc <= acc_add;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
        end
        ST_SIGN: begin
          {HI, LO} <= acc_fin;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult32.sv
module tb_seq_mult32;

  logic        CLK;
  logic        RESET;
  logic        START;
  logic        SIGNED;
  logic [31:0] A;
  logic [31:0] B;
  logic        BUSY;
  logic        DONE;
  logic [31:0] HI;
  logic [31:0] LO;

  seq_mult32 #(.WIDTH(32)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .START (START),
    .SIGNED(SIGNED),
    .A     (A),
    .B     (B),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .HI    (HI),
    .LO    (LO)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic [63:0] prod;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          last_start = -1;
  logic [63:0] last_prod = '0;
  logic [63:0] held = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [63:0] ref_prod(input logic sg, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa;
    longint sb2;
    logic [63:0] ua;
    logic [63:0] ub;
    if (sg) begin
      sa  = longint'($signed(a));
      sb2 = longint'($signed(b));
      return 64'(sa * sb2);
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return ua * ub;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares DUT outputs with the timing model and the scoreboard.
  always @(negedge CLK) begin
    logic exp_busy;
    logic exp_done;
    exp_t e;
    exp_busy = (last_start >= 0) && (cyc >= last_start) && (cyc <= last_start + 32);
    exp_done = (last_start >= 0) && (cyc == last_start + 33);
    if (exp_done) held = last_prod;
    chk("busy", 64'(BUSY), 64'(exp_busy));
    chk("done", 64'(DONE), 64'(exp_done));
    chk("hold_hilo", {HI, LO}, held);
    if (DONE === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 64'(1), 64'(0));
      end else begin
        e = sb.pop_front();
        chk("product", {HI, LO}, e.prod);
        chk("latency", 64'(cyc), 64'(e.due));
      end
    end
  end

  // One clock of stimulus; the model decides whether START is accepted.
  task automatic drive(input logic st, input logic sg, input logic [31:0] a,
                       input logic [31:0] b, output logic acc);
    exp_t e;
    START  = st;
    SIGNED = sg;
    A      = a;
    B      = b;
    @(posedge CLK);
    #1;
    acc = st && RESET && ((last_start < 0) || (cyc >= last_start + 35));
    if (acc) begin
      e.prod = ref_prod(sg, a, b);
      e.due  = cyc + 33;
      sb.push_back(e);
      last_prod  = e.prod;
      last_start = cyc;
    end
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'd0, 32'd0, acc);
  endtask

  function automatic logic [31:0] pick();
    int unsigned r;
    r = $urandom_range(0, 9);
    case (r)
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      4: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   n;
    START  = 1'b0;
    SIGNED = 1'b0;
    A      = '0;
    B      = '0;
    RESET  = 1'b1;
    #1 RESET = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b1;
    idle(10);

    // Signed mixed sign: -3 * 5
    drive(1'b1, 1'b1, 32'hFFFF_FFFD, 32'd5, acc);
    idle(40);

    // Extremes
    drive(1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, acc);
    idle(40);
    drive(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, acc);
    idle(40);

    // START held through RUN, SIGN and DONE is ignored
    drive(1'b1, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, acc);
    for (int i = 0; i < 34; i++) drive(1'b1, 1'b0, 32'd7, 32'd7, acc);
    idle(40);

    // Reset mid-operation
    drive(1'b1, 1'b0, 32'h0000_1234, 32'h0000_0010, acc);
    idle(14);
    RESET = 1'b0;
    #1;
    chk("rst_busy", 64'(BUSY), 64'(0));
    chk("rst_done", 64'(DONE), 64'(0));
    chk("rst_hilo", {HI, LO}, 64'(0));
    sb.delete();
    last_start = -1;
    held       = '0;
    last_prod  = '0;
    idle(2);
    RESET = 1'b1;
    drive(1'b1, 1'b0, 32'h0000_1234, 32'h0000_0010, acc);
    idle(40);

    // Back-to-back with START held high
    n = 0;
    for (int i = 0; i < 100 && n < 2; i++) begin
      if (n == 0) drive(1'b1, 1'b0, 32'd3, 32'd4, acc);
      else        drive(1'b1, 1'b1, 32'd0, 32'hFFFF_FFFF, acc);
      if (acc) n++;
    end
    idle(40);

    // Random operations with random gaps (short gaps exercise ignored START)
    for (int i = 0; i < 24; i++) begin
      drive(1'b1, 1'($urandom_range(0, 1)), pick(), pick(), acc);
      idle(int'($urandom_range(0, 40)));
    end
    idle(40);

    chk("drain", 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
